// File: rtl/lane_arb_pkg.sv
// lane_arb_pkg: state and last-served encodings, default timing and the shared arbitration rule
package lane_arb_pkg;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT_E = 3'd1,
      CLEAR_E = 3'd2,
      GRANT_W = 3'd3,
      CLEAR_W = 3'd4
   } state_t;
   typedef enum logic {LAST_E = 1'b0, LAST_W = 1'b1} last_t;
   localparam int DEF_MIN_GREEN    = 2;
   localparam int DEF_MAX_GREEN    = 8;
   localparam int DEF_CLEAR_CYCLES = 3;
   localparam int DEF_CW           = 4;
   // A tie goes to the side that was not served last
   function automatic state_t arb(input logic re, input logic rw, input last_t last);
      return (re && rw) ? ((last == LAST_W) ? GRANT_E : GRANT_W) :
             re ? GRANT_E : rw ? GRANT_W : IDLE;
   endfunction
endpackage

// File: rtl/lane_arbiter_if.sv
// lane_arbiter_if: request/grant bundle between the two requesters and the arbiter
interface lane_arbiter_if;
   logic       req_e;
   logic       req_w;
   logic       go_e;
   logic       go_w;
   logic       idle;
   logic [2:0] state;
   modport master(output req_e, req_w, input go_e, go_w, idle, state);
   modport slave(input req_e, req_w, output go_e, go_w, idle, state);
endinterface

// File: rtl/lane_timer.sv
// lane_timer: loadable up-counter that restarts at 1 and holds at a saturation value
module lane_timer #(
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          en,
   input  logic [CW-1:0] sat,
   output logic [CW-1:0] cnt
);
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= CW'(1);
      else if (en && cnt < sat) cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/lane_arbiter.sv
// lane_arbiter: one-lane east/west arbiter with min/max green, all-stop clearance and round-robin ties
module lane_arbiter import lane_arb_pkg::*; #(
   parameter int MIN_GREEN    = DEF_MIN_GREEN,
   parameter int MAX_GREEN    = DEF_MAX_GREEN,
   parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES,
   parameter int CW           = DEF_CW
) (
   input logic           clk,
   input logic           rst,
   lane_arbiter_if.slave bus
);
   localparam logic [CW-1:0] MIN_C = CW'(MIN_GREEN);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_GREEN);
   localparam logic [CW-1:0] CLR_C = CW'(CLEAR_CYCLES);
   state_t        state, nxt;
   last_t         last, last_nxt;
   logic          load;
   logic [CW-1:0] sat;
   logic [CW-1:0] cnt;
   logic          min_ok, max_ok;
   assign min_ok = cnt >= MIN_C;
   assign max_ok = cnt >= MAX_C;
   lane_timer #(.CW(CW)) u_timer (
      .clk (clk),
      .rst (rst),
      .load(load),
      .en  (state != IDLE),
      .sat (sat),
      .cnt (cnt)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         last  <= LAST_W;
      end else begin
         state <= nxt;
         last  <= last_nxt;
      end
   end
   always_comb begin
      nxt      = state;
      last_nxt = last;
      sat      = MAX_C;
      unique case (state)
         IDLE: nxt = arb(bus.req_e, bus.req_w, last);
         GRANT_E:
            if (min_ok && (!bus.req_e || (bus.req_w && max_ok))) begin
               nxt      = CLEAR_E;
               last_nxt = LAST_E;
            end
         GRANT_W:
            if (min_ok && (!bus.req_w || (bus.req_e && max_ok))) begin
               nxt      = CLEAR_W;
               last_nxt = LAST_W;
            end
         CLEAR_E, CLEAR_W: begin
            sat = CLR_C;
            if (cnt == CLR_C) nxt = arb(bus.req_e, bus.req_w, last);
         end
         default: nxt = IDLE;
      endcase
      // every entry into a grant or clearance restarts the count at 1
      load = (nxt != state) && (nxt != IDLE);
   end
   assign bus.go_e  = state == GRANT_E;
   assign bus.go_w  = state == GRANT_W;
   assign bus.idle  = state == IDLE;
   assign bus.state = state;
endmodule

// File: tb/tb_lane_arbiter.sv
// tb_lane_arbiter: run-length vector table plus contention and reset-mid-grant sequences,
// expected states queued at drive time and checked one cycle later
module tb_lane_arbiter;
   import lane_arb_pkg::*;
   typedef struct {
      logic   rst;
      logic   e;
      logic   w;
      state_t st;
      int     n;
   } run_t;
   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total = 0;
   int   cyc = 0;
   string phase;
   state_t exp_q[$];
   run_t tbl[22];
   lane_arbiter_if bus();
   lane_arbiter dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   task automatic check();
      state_t x;
      logic [5:0] act, exp;
      x   = exp_q.pop_front();
      act = {bus.go_e, bus.go_w, bus.idle, bus.state};
      exp = {x == GRANT_E, x == GRANT_W, x == IDLE, 3'(x)};
      total++;
      if (act !== exp)
         $display("FAIL %s cyc %0d: got go_e/go_w/idle/state=%b/%b/%b/%0d, want %b/%b/%b/%0d",
                  phase, cyc, act[5], act[4], act[3], act[2:0], exp[5], exp[4], exp[3], exp[2:0]);
      else passed++;
   endtask
   task automatic step(input logic r, input logic e, input logic w, input state_t st);
      rst = r;
      bus.req_e = e;
      bus.req_w = w;
      exp_q.push_back(st);
      @(posedge clk);
      #1;
      cyc++;
      check();
   endtask
   function automatic state_t pat(input int k);
      int m;
      m = k % 22;
      return (m < 8) ? GRANT_E : (m < 11) ? CLEAR_E : (m < 19) ? GRANT_W : CLEAR_W;
   endfunction
   initial begin
      tbl = '{
         '{1'b1, 1'b1, 1'b1, IDLE,    2},
         '{1'b0, 1'b1, 1'b1, GRANT_E, 1},
         '{1'b0, 1'b0, 1'b0, GRANT_E, 1},
         '{1'b0, 1'b0, 1'b0, CLEAR_E, 3},
         '{1'b0, 1'b0, 1'b0, IDLE,    1},
         '{1'b0, 1'b1, 1'b0, GRANT_E, 5},
         '{1'b0, 1'b0, 1'b0, CLEAR_E, 3},
         '{1'b0, 1'b0, 1'b0, IDLE,    1},
         '{1'b0, 1'b0, 1'b1, GRANT_W, 2},
         '{1'b0, 1'b0, 1'b0, CLEAR_W, 1},
         '{1'b0, 1'b1, 1'b1, CLEAR_W, 2},
         '{1'b0, 1'b1, 1'b1, GRANT_E, 1},
         '{1'b0, 1'b0, 1'b0, GRANT_E, 1},
         '{1'b0, 1'b0, 1'b0, CLEAR_E, 3},
         '{1'b0, 1'b0, 1'b0, IDLE,    1},
         '{1'b0, 1'b1, 1'b0, GRANT_E, 12},
         '{1'b0, 1'b1, 1'b1, CLEAR_E, 3},
         '{1'b0, 1'b1, 1'b1, GRANT_W, 1},
         '{1'b0, 1'b0, 1'b0, GRANT_W, 1},
         '{1'b0, 1'b0, 1'b0, CLEAR_W, 1},
         '{1'b0, 1'b1, 1'b0, CLEAR_W, 2},
         '{1'b0, 1'b0, 1'b0, IDLE,    1}
      };
      rst = 1'b1;
      bus.req_e = 1'b0;
      bus.req_w = 1'b0;
      phase = "table";
      foreach (tbl[i])
         for (int j = 0; j < tbl[i].n; j++) step(tbl[i].rst, tbl[i].e, tbl[i].w, tbl[i].st);
      phase = "contention";
      step(1'b1, 1'b1, 1'b1, IDLE);
      for (int k = 0; k < 44; k++) step(1'b0, 1'b1, 1'b1, pat(k));
      phase = "reset_mid_grant";
      step(1'b1, 1'b0, 1'b0, IDLE);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b1, GRANT_W);
      step(1'b1, 1'b1, 1'b1, IDLE);
      step(1'b0, 1'b1, 1'b1, GRANT_E);
      step(1'b0, 1'b1, 1'b1, GRANT_E);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/lane_arbiter.md
# lane_arbiter

Synchronous controller that shares a single one-lane resource between an east requester and a west requester. It grants at most one direction at a time, enforces minimum and maximum green times, and inserts an all-stop clearance interval between grants. Arbitration is round-robin with east priority on the first tie. It sits above the east/west direction state flops and drives their per-direction enables.

## Interface
- `MIN_GREEN`, 2, minimum cycles a grant is held once issued
- `MAX_GREEN`, 8, maximum grant cycles while the other side is waiting
- `CLEAR_CYCLES`, 3, all-stop cycles between any two grants
- `CW`, 4, counter width; requires 1 ≤ MIN_GREEN ≤ MAX_GREEN < 2^CW and 1 ≤ CLEAR_CYCLES < 2^CW
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `req_e`  in  1  east request level
- `req_w`  in  1  west request level
- `go_e`  out  1  east grant (registered)
- `go_w`  out  1  west grant (registered)
- `idle`  out  1  high only in IDLE (no grant, no clearance)
- `state`  out  3  current FSM state, for debug

## Operation
- States: IDLE, GRANT_E, CLEAR_E, GRANT_W, CLEAR_W.
- Outputs are decoded from the registered state: go_e=(GRANT_E), go_w=(GRANT_W), idle=(IDLE). go_e and go_w are never high together.
- Internal regs: `cnt`[CW-1:0] and `last` (0=E served last, 1=W served last).
- Arbitration function A(last) is used in IDLE and at the end of CLEAR:
  - both requests high → grant the side opposite `last`;
  - one request high → grant that side;
  - none → IDLE.
- IDLE: apply A(last). On entry to GRANT_x, cnt←1.
- GRANT_x:
  - cnt increments each cycle, saturating at MAX_GREEN.
  - Exit when cnt ≥ MIN_GREEN and (!req_x or (req_other and cnt ≥ MAX_GREEN)).
  - On exit: next state CLEAR_x, cnt←1, last←x.
  - With no opposing request, the grant persists indefinitely while req_x stays high.
- CLEAR_x: cnt increments. When cnt == CLEAR_CYCLES, apply A(last) to choose the next state. The same side may be re-granted if only it requests.
- A request that drops before MIN_GREEN is reached does not shorten the grant.
- Requests are levels; no latching. A request raised and dropped entirely inside a CLEAR interval is lost.

## Timing
- Reset (any state, any cycle): at the next edge, state=IDLE, go_e=go_w=0, idle=1, cnt=0, last=1 (W), so east wins the first tie. rst has priority over all transitions.
- Request latency: req sampled at edge n → go asserted after edge n; one cycle from request to grant.
- Grant length: max(MIN_GREEN, number of edges at which req_x is sampled high). Under contention the grant is capped at MAX_GREEN.
- Clearance: exactly CLEAR_CYCLES cycles with go_e=go_w=0 and idle=0.
- Release: after req_x drops with cnt ≥ MIN_GREEN, go_x falls at the edge that samples the drop.
- Simultaneous req_e/req_w at IDLE or at end of CLEAR: resolved by `last` only, with no further delay.

## Structure
- Shared package `lane_arb_pkg`:
  - state encodings (IDLE=0, GRANT_E=1, CLEAR_E=2, GRANT_W=3, CLEAR_W=4);
  - default timing constants;
  - the `last` encoding.
- Sub-module `lane_timer`: loadable saturating up-counter (load-to-1, enable, saturate value). It owns `cnt`. The top level holds the FSM, `last`, and output decode.

## Test plan
- Reset: hold rst 2 cycles with req_e=req_w=1 → go_e=go_w=0, idle=1, state=0. First grant after release is go_e.
- Single east request: req_e sampled high at edges 1–5 → go_e high after edges 1–5. CLEAR_E after edges 6–8 (idle=0, go_e=go_w=0). idle=1 after edge 9.
- Short pulse: req_e high for one edge only → go_e held for exactly 2 cycles, then 3 clearance cycles, then IDLE.
- Contention: req_e=req_w=1 continuously from reset release → repeating sequence go_e 8 cycles, clear 3, go_w 8 cycles, clear 3. go_e and go_w never overlap.
- Tie after west service: W granted alone, then both request during CLEAR_W → go_e is granted at the end of the clearance.
- Reset mid-grant: rst asserted while go_w=1 with cnt=4 → go_w=0, idle=1 after that edge. A subsequent tie grants go_e.
